// File: rtl/dma_bus_arbiter.sv
// Single data-memory port shared between the CPU MEM stage and a BR/BG DMA engine.
// Fixed-latency accesses; the DMA burst is bounded so a waiting CPU cannot starve.
module dma_bus_arbiter #(
  parameter int LATENCY   = 2,
  parameter int MAX_BURST = 4,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_stall,
  input  logic                 dma_br,
  output logic                 dma_bg,
  input  logic                 dma_rd,
  input  logic                 dma_wr,
  input  logic [WORD_SIZE-1:0] dma_addr,
  input  logic [WORD_SIZE-1:0] dma_wdata,
  output logic [WORD_SIZE-1:0] dma_rdata,
  output logic                 dma_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] dma_word_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    DMA_IDLE = 2'd2,
    DMA_ACC  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_lat_cnt;
  logic [3:0]           w_lat_nxt;
  logic [3:0]           r_burst_cnt;
  logic [3:0]           w_burst_nxt;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] w_addr_nxt;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] w_wdata_nxt;
  logic                 r_is_wr;
  logic                 w_is_wr_nxt;
  logic [WORD_SIZE-1:0] r_cpu_rdata;
  logic [WORD_SIZE-1:0] w_cpu_rdata_nxt;
  logic [WORD_SIZE-1:0] r_dma_rdata;
  logic [WORD_SIZE-1:0] w_dma_rdata_nxt;
  logic                 r_cpu_ready;
  logic                 w_cpu_ready_nxt;
  logic                 r_dma_ready;
  logic                 w_dma_ready_nxt;
  logic                 r_bg;
  logic                 w_bg_nxt;
  logic [WORD_SIZE-1:0] r_word_cnt;
  logic [WORD_SIZE-1:0] w_word_cnt_nxt;

  logic w_cpu_req;
  logic w_access;
  logic w_lat_done;
  logic w_preempt;

  assign w_cpu_req  = cpu_rd | cpu_wr;
  assign w_access   = (r_state == CPU_ACC) || (r_state == DMA_ACC);
  assign w_lat_done = (r_lat_cnt == LAT_LAST);
  // Cycle stealing: only an idle grant with an exhausted burst yields to a waiting CPU.
  assign w_preempt  = (MAX_BURST != 0) && (int'(r_burst_cnt) >= MAX_BURST) && w_cpu_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_lat_cnt   <= '0;
      r_burst_cnt <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_wr     <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      r_bg        <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lat_cnt   <= w_lat_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_is_wr     <= w_is_wr_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dma_rdata <= w_dma_rdata_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_dma_ready <= w_dma_ready_nxt;
      r_bg        <= w_bg_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lat_nxt       = r_lat_cnt;
    w_burst_nxt     = r_burst_cnt;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_is_wr_nxt     = r_is_wr;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dma_rdata_nxt = r_dma_rdata;
    w_cpu_ready_nxt = 1'b0;
    w_dma_ready_nxt = 1'b0;
    w_bg_nxt        = r_bg;
    w_word_cnt_nxt  = r_word_cnt;
    case (r_state)
      IDLE: begin
        // r_cpu_ready blocks re-issue while the pipeline still holds the finished request.
        if (!r_cpu_ready && w_cpu_req) begin
          w_state_nxt = CPU_ACC;
          w_addr_nxt  = cpu_addr;
          w_wdata_nxt = cpu_wdata;
          w_is_wr_nxt = cpu_wr;
          w_lat_nxt   = '0;
        end else if (dma_br) begin
          w_state_nxt = DMA_IDLE;
          w_bg_nxt    = 1'b1;
          w_burst_nxt = '0;
        end
      end
      CPU_ACC: begin
        if (w_lat_done) begin
          w_state_nxt     = IDLE;
          w_lat_nxt       = '0;
          w_cpu_ready_nxt = 1'b1;
          if (!r_is_wr) w_cpu_rdata_nxt = mem_rdata;
        end else begin
          w_lat_nxt = r_lat_cnt + 4'd1;
        end
      end
      DMA_IDLE: begin
        if (!dma_br) begin
          w_state_nxt = IDLE;
          w_bg_nxt    = 1'b0;
        end else if (dma_rd || dma_wr) begin
          w_state_nxt = DMA_ACC;
          w_addr_nxt  = dma_addr;
          w_wdata_nxt = dma_wdata;
          w_is_wr_nxt = dma_wr;
          w_lat_nxt   = '0;
        end else if (w_preempt) begin
          w_state_nxt = IDLE;
          w_bg_nxt    = 1'b0;
        end
      end
      DMA_ACC: begin
        if (w_lat_done) begin
          w_state_nxt     = DMA_IDLE;
          w_lat_nxt       = '0;
          w_dma_ready_nxt = 1'b1;
          w_word_cnt_nxt  = r_word_cnt + WORD_SIZE'(1);
          w_burst_nxt     = (r_burst_cnt == 4'd15) ? r_burst_cnt : r_burst_cnt + 4'd1;
          if (!r_is_wr) w_dma_rdata_nxt = mem_rdata;
        end else begin
          w_lat_nxt = r_lat_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign mem_read     = w_access & ~r_is_wr;
  assign mem_write    = w_access & r_is_wr;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign cpu_rdata    = r_cpu_rdata;
  assign cpu_ready    = r_cpu_ready;
  assign cpu_stall    = w_cpu_req & ~r_cpu_ready;
  assign dma_rdata    = r_dma_rdata;
  assign dma_ready    = r_dma_ready;
  assign dma_bg       = r_bg;
  assign dma_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: one instance with MAX_BURST=4 and one with
// MAX_BURST=0 share stimulus; sel chooses which instance the memory model and checks follow.
module tb_dma_bus_arbiter;

  localparam int LAT = 2;
  localparam int WS  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_rd, cpu_wr, dma_br, dma_rd, dma_wr;
  logic [WS-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [WS-1:0] mem_rdata;
  logic [WS-1:0] m_rd_val;
  logic [3:0]    m_rd_cnt;
  logic          sel;

  logic [WS-1:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_word_cnt;
  logic          a_cpu_ready, a_cpu_stall, a_dma_bg, a_dma_ready, a_mem_read, a_mem_write;
  logic [WS-1:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_word_cnt;
  logic          b_cpu_ready, b_cpu_stall, b_dma_bg, b_dma_ready, b_mem_read, b_mem_write;

  logic [WS-1:0] s_cpu_rdata, s_dma_rdata, s_mem_addr, s_mem_wdata, s_word_cnt;
  logic          s_cpu_ready, s_cpu_stall, s_dma_bg, s_dma_ready, s_mem_read, s_mem_write;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_bus_arbiter #(.LATENCY(LAT), .MAX_BURST(4), .WORD_SIZE(WS)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready), .cpu_stall(a_cpu_stall),
    .dma_br(dma_br), .dma_bg(a_dma_bg), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(a_dma_rdata), .dma_ready(a_dma_ready),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .dma_word_cnt(a_word_cnt)
  );

  dma_bus_arbiter #(.LATENCY(LAT), .MAX_BURST(0), .WORD_SIZE(WS)) u_dut_nb (
    .clk(clk), .reset_n(reset_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready), .cpu_stall(b_cpu_stall),
    .dma_br(dma_br), .dma_bg(b_dma_bg), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(b_dma_rdata), .dma_ready(b_dma_ready),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .dma_word_cnt(b_word_cnt)
  );

  assign s_cpu_rdata = sel ? b_cpu_rdata : a_cpu_rdata;
  assign s_dma_rdata = sel ? b_dma_rdata : a_dma_rdata;
  assign s_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign s_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign s_word_cnt  = sel ? b_word_cnt  : a_word_cnt;
  assign s_cpu_ready = sel ? b_cpu_ready : a_cpu_ready;
  assign s_cpu_stall = sel ? b_cpu_stall : a_cpu_stall;
  assign s_dma_bg    = sel ? b_dma_bg    : a_dma_bg;
  assign s_dma_ready = sel ? b_dma_ready : a_dma_ready;
  assign s_mem_read  = sel ? b_mem_read  : a_mem_read;
  assign s_mem_write = sel ? b_mem_write : a_mem_write;

  // Memory model: read data is valid only in the last strobe cycle, garbage otherwise.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        m_rd_cnt <= '0;
    else if (s_mem_read) m_rd_cnt <= m_rd_cnt + 4'd1;
    else                 m_rd_cnt <= '0;
  end
  assign mem_rdata = (s_mem_read && (m_rd_cnt == 4'(LAT - 1))) ? m_rd_val : 16'h0BAD;

  int            mon_rd = 0, mon_wr = 0, mon_both = 0, mon_dma_rdy = 0, mon_bg_rise = 0;
  logic          mon_wr_q = 1'b0, mon_bg_q = 1'b0;
  logic [WS-1:0] last_rd_addr = '0;
  logic [WS-1:0] wlog_addr[$];
  logic [WS-1:0] wlog_data[$];

  always @(negedge clk) begin
    if (s_mem_read)                 mon_rd <= mon_rd + 1;
    if (s_mem_write)                mon_wr <= mon_wr + 1;
    if (s_mem_read && s_mem_write)  mon_both <= mon_both + 1;
    if (s_dma_ready)                mon_dma_rdy <= mon_dma_rdy + 1;
    if (s_dma_bg && !mon_bg_q)      mon_bg_rise <= mon_bg_rise + 1;
    if (s_mem_read)                 last_rd_addr <= s_mem_addr;
    if (s_mem_write && !mon_wr_q) begin
      wlog_addr.push_back(s_mem_addr);
      wlog_data.push_back(s_mem_wdata);
    end
    mon_wr_q <= s_mem_write;
    mon_bg_q <= s_dma_bg;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_br = 1'b0; dma_rd = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  // CPU holds the request until it sees cpu_ready, then releases it one cycle later.
  task automatic cpu_access(input logic wr, input logic [WS-1:0] addr, input logic [WS-1:0] data,
                            output int cyc, output logic bg_at_rdy);
    cpu_addr = addr; cpu_wdata = data; cpu_wr = wr; cpu_rd = !wr;
    cyc = -1; bg_at_rdy = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (s_cpu_ready) begin
        cyc = i; bg_at_rdy = s_dma_bg;
        break;
      end
    end
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  // DMA writes n words, idling one cycle after each dma_ready; the CPU read arrives after word 1.
  task automatic run_burst(input int n, output int words_at_cpu, output int stall_gaps,
                           output logic [WS-1:0] rdata, output int done);
    int   issued;
    logic cpu_st, cpu_dn, drop;
    issued = 0; done = 0; cpu_st = 1'b0; cpu_dn = 1'b0; drop = 1'b0;
    words_at_cpu = -1; stall_gaps = 0; rdata = '0;
    m_rd_val = 16'h1357;
    dma_br = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (drop) begin cpu_rd = 1'b0; drop = 1'b0; end
      if (cpu_st && !cpu_dn) begin
        if (s_cpu_ready) begin
          cpu_dn = 1'b1; drop = 1'b1; words_at_cpu = done; rdata = s_cpu_rdata;
        end else if (!s_cpu_stall) begin
          stall_gaps++;
        end
      end
      if (s_dma_ready) begin
        done++;
        dma_wr = 1'b0;
        if (done == 1 && !cpu_st) begin
          cpu_rd = 1'b1; cpu_addr = 16'h0040; cpu_st = 1'b1;
        end
        if (done == n) dma_br = 1'b0;
      end else if (s_dma_bg && dma_br && !dma_wr && issued < n) begin
        dma_wr = 1'b1; dma_addr = 16'h0100 + 16'(issued); dma_wdata = 16'hD000 + 16'(issued);
        issued++;
      end
      if (done == n && cpu_dn && !drop) break;
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cyc, wac, gaps, nw, b_rd, b_wr, b_rdy, b_bg, b_log;
    logic          bgr;
    logic [WS-1:0] rd;

    sel = 1'b0;
    m_rd_val = '0;
    reset_n = 1'b0;
    clear_inputs();
    tick();
    check("rst_bg",        {31'd0, a_dma_bg}, 0);
    check("rst_cpu_ready", {31'd0, a_cpu_ready}, 0);
    check("rst_strobes",   {30'd0, a_mem_read, a_mem_write}, 0);
    check("rst_cpu_rdata", a_cpu_rdata, 0);
    check("rst_dma_rdata", a_dma_rdata, 0);
    check("rst_word_cnt",  a_word_cnt, 0);
    reset_n = 1'b1;
    tick();

    // CPU read of 0x0010
    b_rd = mon_rd; b_wr = mon_wr;
    m_rd_val = 16'hBEEF;
    cpu_access(1'b0, 16'h0010, 16'h0000, cyc, bgr);
    check("rd_latency", cyc, LAT + 1);
    check("rd_data", a_cpu_rdata, 16'hBEEF);
    tick(); tick();
    check("rd_strobe_cycles", mon_rd - b_rd, LAT);
    check("rd_no_write", mon_wr - b_wr, 0);
    check("rd_addr", last_rd_addr, 16'h0010);

    // CPU write and DMA request in the same cycle: CPU first
    b_wr = mon_wr; b_log = wlog_addr.size();
    dma_br = 1'b1;
    cpu_access(1'b1, 16'h0020, 16'h5A5A, cyc, bgr);
    check("wr_latency", cyc, LAT + 1);
    check("wr_bg_at_ready", {31'd0, bgr}, 0);
    check("wr_bg_after", {31'd0, a_dma_bg}, 1);
    check("wr_strobe_cycles", mon_wr - b_wr, LAT);
    check("wr_log_addr", (wlog_addr.size() > b_log) ? wlog_addr[b_log] : 16'hFFFF, 16'h0020);
    check("wr_log_data", (wlog_data.size() > b_log) ? wlog_data[b_log] : 16'hFFFF, 16'h5A5A);
    check("wr_rdata_kept", a_cpu_rdata, 16'hBEEF);
    dma_br = 1'b0;
    tick();
    check("release_bg", {31'd0, a_dma_bg}, 0);

    // Bounded burst, MAX_BURST=4
    do_reset();
    b_rd = mon_rd; b_wr = mon_wr; b_bg = mon_bg_rise; b_log = wlog_addr.size();
    run_burst(6, wac, gaps, rd, nw);
    check("mb4_words_done", nw, 6);
    check("mb4_words_before_cpu", wac, 4);
    check("mb4_stall_gaps", gaps, 0);
    check("mb4_cpu_rdata", rd, 16'h1357);
    check("mb4_word_cnt", a_word_cnt, 6);
    check("mb4_bg_grants", mon_bg_rise - b_bg, 2);
    check("mb4_wr_cycles", mon_wr - b_wr, 6 * LAT);
    check("mb4_rd_cycles", mon_rd - b_rd, LAT);
    check("mb4_log_addr3", (wlog_addr.size() > b_log + 3) ? wlog_addr[b_log + 3] : 16'hFFFF, 16'h0103);
    check("mb4_log_data5", (wlog_data.size() > b_log + 5) ? wlog_data[b_log + 5] : 16'hFFFF, 16'hD005);

    // No preemption, MAX_BURST=0
    sel = 1'b1;
    do_reset();
    b_bg = mon_bg_rise; b_wr = mon_wr;
    run_burst(6, wac, gaps, rd, nw);
    check("mb0_words_done", nw, 6);
    check("mb0_words_before_cpu", wac, 6);
    check("mb0_stall_gaps", gaps, 0);
    check("mb0_cpu_rdata", rd, 16'h1357);
    check("mb0_word_cnt", b_word_cnt, 6);
    check("mb0_bg_grants", mon_bg_rise - b_bg, 1);
    check("mb0_wr_cycles", mon_wr - b_wr, 6 * LAT);
    sel = 1'b0;

    // Reset in the first cycle of a DMA write
    do_reset();
    b_rdy = mon_dma_rdy;
    dma_br = 1'b1;
    tick();
    check("mid_bg_granted", {31'd0, a_dma_bg}, 1);
    dma_wr = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'h1111;
    tick();
    check("mid_write_active", {31'd0, a_mem_write}, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_bg", {31'd0, a_dma_bg}, 0);
    check("mid_rst_write", {31'd0, a_mem_write}, 0);
    check("mid_rst_ready", {31'd0, a_dma_ready}, 0);
    check("mid_rst_word_cnt", a_word_cnt, 0);
    clear_inputs();
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    check("mid_no_dma_ready", mon_dma_rdy - b_rdy, 0);
    m_rd_val = 16'h7E57;
    cpu_access(1'b0, 16'h1234, 16'h0000, cyc, bgr);
    check("post_rst_latency", cyc, LAT + 1);
    check("post_rst_rdata", a_cpu_rdata, 16'h7E57);
    check("post_rst_addr", last_rd_addr, 16'h1234);

    // DMA command without grant, and bus request dropped while granted
    b_rd = mon_rd; b_wr = mon_wr;
    dma_wr = 1'b1; dma_addr = 16'h0300;
    tick(); tick(); tick();
    check("nogrant_bg", {31'd0, a_dma_bg}, 0);
    dma_wr = 1'b0; dma_br = 1'b1;
    tick();
    check("grant_bg", {31'd0, a_dma_bg}, 1);
    dma_br = 1'b0; dma_wr = 1'b1;
    tick();
    check("drop_br_bg", {31'd0, a_dma_bg}, 0);
    tick();
    check("ignored_cmd_strobes", (mon_rd - b_rd) + (mon_wr - b_wr), 0);
    dma_wr = 1'b0;

    // DMA read word
    m_rd_val = 16'hCAFE;
    dma_br = 1'b1;
    tick();
    dma_rd = 1'b1; dma_addr = 16'h0300;
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (a_dma_ready) begin cyc = i; break; end
    end
    clear_inputs();
    check("dma_rd_latency", cyc, LAT + 1);
    check("dma_rdata", a_dma_rdata, 16'hCAFE);
    check("dma_rd_addr", last_rd_addr, 16'h0300);
    check("dma_rd_word_cnt", a_word_cnt, 1);
    tick(); tick();
    check("never_both_strobes", mon_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
